sensor_poll_scheduler: RTL and testbench

Periodic read scheduler for the sensor front end. It consumes the slow divided clock from the clock divider, counts its rising edges, and issues one-cycle start requests to the sensor protocol driver at a programmable interval. It tracks each transaction to completion or timeout and keeps saturating success and error counters for the display/report path.

---
 rtl/sensor_poll_scheduler.sv | 146 ++++++++++++++
 tb/tb_sensor_poll_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_poll_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : sensor_poll_scheduler
//  Purpose  : Issues periodic one-cycle start requests to the sensor protocol
//             driver, spaced by a programmable number of div_clk rising edges.
//             Tracks each transaction to done or timeout and keeps saturating
//             success / error counters.
//  Revision : 1.0 - initial release
// ============================================================================
module sensor_poll_scheduler #(
    parameter int INTERVAL_WIDTH = 8,
    parameter int TIMEOUT_TICKS  = 3,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      div_clk,
    input  logic                      enable,
    input  logic [INTERVAL_WIDTH-1:0] interval,
    input  logic                      sensor_busy,
    input  logic                      sensor_done,
    input  logic                      sensor_error,
    output logic                      start,
    output logic                      polling,
    output logic                      timeout,
    output logic [COUNT_WIDTH-1:0]    read_count,
    output logic [COUNT_WIDTH-1:0]    error_count
);

    // One extra bit so TIMEOUT_TICKS-1 always fits, even for powers of two.
    localparam int TMO_W = $clog2(TIMEOUT_TICKS) + 1;

    localparam logic [TMO_W-1:0]          TMO_LAST  = TMO_W'(TIMEOUT_TICKS - 1);
    localparam logic [TMO_W-1:0]          TMO_ONE   = TMO_W'(1);
    localparam logic [INTERVAL_WIDTH:0]   TICK_ONE  = (INTERVAL_WIDTH+1)'(1);
    localparam logic [INTERVAL_WIDTH-1:0] IVL_ONE   = INTERVAL_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0]    CNT_ONE   = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0]    CNT_MAX   = {COUNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        COUNT     = 2'd3
    } state_t;

    state_t                    state;
    logic                      div_clk_q;
    logic [INTERVAL_WIDTH-1:0] tick_cnt;
    logic [TMO_W-1:0]          tmo_cnt;

    logic                      tick;
    logic [INTERVAL_WIDTH-1:0] interval_eff;
    logic [INTERVAL_WIDTH:0]   tick_next;
    logic                      interval_hit;

    // Rising-edge detect on the divided clock; interval 0 is treated as 1.
    // The tick count is widened by one bit so the +1 cannot wrap.
    assign tick         = div_clk & ~div_clk_q;
    assign interval_eff = (interval == '0) ? IVL_ONE : interval;
    assign tick_next    = {1'b0, tick_cnt} + TICK_ONE;
    assign interval_hit = (tick_next >= {1'b0, interval_eff});

    // Scheduler FSM with registered start/polling/timeout and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            div_clk_q   <= 1'b0;
            tick_cnt    <= '0;
            tmo_cnt     <= '0;
            start       <= 1'b0;
            polling     <= 1'b0;
            timeout     <= 1'b0;
            read_count  <= '0;
            error_count <= '0;
        end else begin
            div_clk_q <= div_clk;
            start     <= 1'b0;
            timeout   <= 1'b0;

            case (state)
                IDLE: begin
                    // First read goes out immediately, without waiting an interval.
                    if (enable) begin
                        state <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (!sensor_busy) begin
                        start   <= 1'b1;
                        polling <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    // Done takes priority over a coincident terminal timeout tick.
                    // A dropped enable lets the transaction finish, then parks in IDLE.
                    if (sensor_done) begin
                        if (sensor_error) begin
                            if (error_count != CNT_MAX) error_count <= error_count + CNT_ONE;
                        end else begin
                            if (read_count != CNT_MAX) read_count <= read_count + CNT_ONE;
                        end
                        polling  <= 1'b0;
                        tick_cnt <= '0;
                        state    <= enable ? COUNT : IDLE;
                    end else if (tick) begin
                        if (tmo_cnt == TMO_LAST) begin
                            timeout  <= 1'b1;
                            if (error_count != CNT_MAX) error_count <= error_count + CNT_ONE;
                            polling  <= 1'b0;
                            tick_cnt <= '0;
                            state    <= enable ? COUNT : IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_ONE;
                        end
                    end
                end

                COUNT: begin
                    // interval is re-sampled on every tick, so live changes apply at once.
                    if (!enable) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (interval_hit) begin
                            state <= ISSUE;
                        end else begin
                            tick_cnt <= tick_next[INTERVAL_WIDTH-1:0];
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sensor_poll_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sensor_poll_scheduler
//  Purpose  : Directed self-checking bench for sensor_poll_scheduler
//             (COUNT_WIDTH=4 so saturation is reachable quickly).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_poll_scheduler;

    localparam int IW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          div_clk = 1'b0;
    logic          enable = 1'b0;
    logic [IW-1:0] interval = '0;
    logic          sensor_busy = 1'b0;
    logic          sensor_done = 1'b0;
    logic          sensor_error = 1'b0;
    logic          start;
    logic          polling;
    logic          timeout;
    logic [CW-1:0] read_count;
    logic [CW-1:0] error_count;

    int tests = 0;
    int fails = 0;
    int exp_rd = 0;

    sensor_poll_scheduler #(
        .INTERVAL_WIDTH (IW),
        .TIMEOUT_TICKS  (3),
        .COUNT_WIDTH    (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .div_clk      (div_clk),
        .enable       (enable),
        .interval     (interval),
        .sensor_busy  (sensor_busy),
        .sensor_done  (sensor_done),
        .sensor_error (sensor_error),
        .start        (start),
        .polling      (polling),
        .timeout      (timeout),
        .read_count   (read_count),
        .error_count  (error_count)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are looked at 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic div_hi();
        div_clk = 1'b1;
        step();
    endtask

    task automatic div_lo();
        div_clk = 1'b0;
        step();
    endtask

    // One full div_clk pulse (rise sampled on the first edge).
    task automatic rise();
        div_hi();
        div_lo();
    endtask

    // One-cycle done pulse.
    task automatic done_pulse(input logic err);
        sensor_done  = 1'b1;
        sensor_error = err;
        step();
        sensor_done  = 1'b0;
        sensor_error = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_start",   start,       0);
        chk("rst_polling", polling,     0);
        chk("rst_timeout", timeout,     0);
        chk("rst_rdcnt",   read_count,  0);
        chk("rst_errcnt",  error_count, 0);
        reset = 1'b1;
        step();

        // ---------------- basic poll, interval=2 ----------------
        interval = 8'd2;
        enable   = 1'b1;
        step();                                   // IDLE -> ISSUE
        chk("en_lat_nostart", start, 0);
        step();                                   // start registered
        chk("en_lat_start",   start,   1);
        chk("en_lat_polling", polling, 1);
        step();
        chk("start_one_cycle", start,   0);
        chk("polling_held",    polling, 1);
        done_pulse(1'b0);
        chk("basic_rd1",      read_count, 1);
        chk("basic_poll_off", polling,    0);
        rise();
        chk("basic_no_early_start", start, 0);
        div_hi();                                 // terminal tick -> ISSUE
        chk("basic_issue_nostart", start, 0);
        div_lo();
        chk("basic_start2", start, 1);

        // ---------------- timeout ----------------
        rise();
        rise();
        chk("tmo_not_yet", timeout, 0);
        div_hi();                                 // 3rd rise after start
        chk("tmo_pulse",   timeout,     1);
        chk("tmo_errcnt",  error_count, 1);
        chk("tmo_polling", polling,     0);
        div_lo();
        chk("tmo_one_cycle", timeout, 0);
        rise();
        div_hi();
        div_lo();
        chk("tmo_next_start", start, 1);
        chk("tmo_rd_same", read_count, 1);

        // ---------------- busy hold-off ----------------
        done_pulse(1'b0);
        chk("busy_rd2", read_count, 2);
        sensor_busy = 1'b1;
        rise();
        rise();                                   // now in ISSUE, held by busy
        begin
            int seen = 0;
            for (int i = 0; i < 50; i++) begin
                step();
                if (start) seen++;
            end
            chk("busy_no_start", seen, 0);
        end
        sensor_busy = 1'b0;
        step();
        chk("busy_release_start", start, 1);

        // ---------------- error and priority ----------------
        done_pulse(1'b1);
        chk("err_errcnt", error_count, 2);
        chk("err_rd_same", read_count, 2);
        rise();
        div_hi();
        div_lo();
        chk("err_next_start", start, 1);
        rise();
        rise();
        sensor_done = 1'b1;                       // coincides with terminal timeout tick
        div_hi();
        sensor_done = 1'b0;
        chk("prio_rd",        read_count,  3);
        chk("prio_no_tmo",    timeout,     0);
        chk("prio_errcnt",    error_count, 2);
        div_lo();
        chk("prio_no_tmo_late", timeout, 0);

        // ---------------- enable drop ----------------
        rise();
        div_hi();
        div_lo();
        chk("drop_start", start, 1);
        enable = 1'b0;
        step();
        chk("drop_still_polling", polling, 1);
        done_pulse(1'b0);
        chk("drop_rd", read_count, 4);
        chk("drop_poll_off", polling, 0);
        begin
            int seen = 0;
            for (int i = 0; i < 4; i++) begin
                div_hi();
                if (start) seen++;
                div_lo();
                if (start) seen++;
            end
            chk("drop_idle_no_start", seen, 0);
        end

        // ---------------- interval = 0 behaves as 1 ----------------
        interval = 8'd0;
        enable   = 1'b1;
        step();
        step();
        chk("ivl0_first_start", start, 1);
        done_pulse(1'b0);
        chk("ivl0_rd", read_count, 5);
        step();
        chk("ivl0_wait_tick", start, 0);
        div_hi();
        div_lo();
        chk("ivl0_start_after_1", start, 1);

        // ---------------- saturation ----------------
        exp_rd = 5;
        for (int i = 0; i < 16; i++) begin
            done_pulse(1'b0);
            exp_rd = (exp_rd < 15) ? exp_rd + 1 : 15;
            chk("sat_rd", read_count, exp_rd);
            div_hi();
            div_lo();
        end
        chk("sat_hold15", read_count, 15);
        chk("sat_in_wait", polling, 1);

        // ---------------- async reset mid-transaction ----------------
        #2;
        reset = 1'b0;
        #1;
        chk("arst_polling", polling,     0);
        chk("arst_start",   start,       0);
        chk("arst_timeout", timeout,     0);
        chk("arst_rdcnt",   read_count,  0);
        chk("arst_errcnt",  error_count, 0);
        step();
        reset = 1'b1;
        step();                                   // IDLE -> ISSUE
        step();
        chk("arst_restart_start", start, 1);
        chk("arst_restart_tmo",   timeout, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
